q_episode_sequencer: RTL

- Drives one Q-learning trial as a series of maze episodes, one agent step at a time.
- Each episode starts at START_STATE. It ends when the agent reaches GOAL_STATE, the step limit is hit, or an illegal state is returned.
- At the end of each episode it pulses ep_finish to the episode counter, then reads trial_stop back. It either begins the next episode or ends the trial.
- Sits between the trial controller (start), the Q-update/environment step engine (step_req/step_ack handshake), and the episode counter (ep_finish/trial_stop).

---
 rtl/q_episode_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/q_episode_sequencer.sv
// Episode sequencer for one Q-learning maze trial: runs episodes step by step
// through the step engine handshake and reports each episode end to the counter.
module q_episode_sequencer #(
    parameter int STATE_W     = 6,
    parameter int NUM_STATES  = 37,
    parameter int START_STATE = 0,
    parameter int GOAL_STATE  = 36,
    parameter int MAX_STEPS   = 255,
    parameter int STEP_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               trial_stop,
    input  logic               step_ack,
    input  logic [STATE_W-1:0] next_state,
    output logic               step_req,
    output logic [STATE_W-1:0] maze_state,
    output logic [STEP_W-1:0]  step_count,
    output logic               ep_finish,
    output logic               timed_out,
    output logic               state_err,
    output logic               busy,
    output logic               trial_done
);

    // state  | meaning
    // IDLE   | waiting for the first start of a trial
    // INIT   | load START_STATE, clear step count and timeout flag
    // REQ    | raise step_req for the next agent step
    // WAIT   | step_req held until step_ack, then classify the new state
    // END    | one-cycle ep_finish pulse to the episode counter
    // SETTLE | sample trial_stop: next episode or finish trial
    // DONE   | trial finished, waiting for a new start
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_REQ,
        S_WAIT,
        S_END,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [STATE_W-1:0] START_S = STATE_W'(START_STATE);
    localparam logic [STATE_W-1:0] GOAL_S  = STATE_W'(GOAL_STATE);
    localparam logic [STATE_W:0]   NUM_S   = (STATE_W+1)'(NUM_STATES);
    localparam logic [STEP_W-1:0]  MAX_S   = STEP_W'(MAX_STEPS);

    state_t             state_q, state_d;
    logic               step_req_q, step_req_d;
    logic [STATE_W-1:0] maze_state_q, maze_state_d;
    logic [STEP_W-1:0]  step_count_q, step_count_d;
    logic               ep_finish_q, ep_finish_d;
    logic               timed_out_q, timed_out_d;
    logic               state_err_q, state_err_d;
    logic               busy_q, busy_d;
    logic               trial_done_q, trial_done_d;

    logic [STEP_W-1:0]  step_inc;
    logic               next_legal;

    assign step_inc   = step_count_q + STEP_W'(1);
    assign next_legal = ({1'b0, next_state} < NUM_S);

    always_comb begin
        state_d      = state_q;
        step_req_d   = step_req_q;
        maze_state_d = maze_state_q;
        step_count_d = step_count_q;
        ep_finish_d  = 1'b0;
        timed_out_d  = timed_out_q;
        state_err_d  = state_err_q;
        busy_d       = busy_q;
        trial_done_d = trial_done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_INIT;
                    busy_d       = 1'b1;
                    trial_done_d = 1'b0;
                    state_err_d  = 1'b0;
                end
            end
            S_INIT: begin
                maze_state_d = START_S;
                step_count_d = '0;
                timed_out_d  = 1'b0;
                state_d      = S_REQ;
            end
            S_REQ: begin
                step_req_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (step_ack) begin
                    step_req_d   = 1'b0;
                    step_count_d = step_inc;
                    if (!next_legal) begin
                        state_err_d = 1'b1;
                        ep_finish_d = 1'b1;
                        state_d     = S_END;
                    end else begin
                        maze_state_d = next_state;
                        // reaching the goal takes priority over the step limit
                        if (next_state == GOAL_S) begin
                            ep_finish_d = 1'b1;
                            state_d     = S_END;
                        end else if (step_inc == MAX_S) begin
                            timed_out_d = 1'b1;
                            ep_finish_d = 1'b1;
                            state_d     = S_END;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_END: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (trial_stop) begin
                    state_d      = S_DONE;
                    busy_d       = 1'b0;
                    trial_done_d = 1'b1;
                end else begin
                    state_d = S_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            step_req_q   <= 1'b0;
            maze_state_q <= START_S;
            step_count_q <= '0;
            ep_finish_q  <= 1'b0;
            timed_out_q  <= 1'b0;
            state_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            trial_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_req_q   <= step_req_d;
            maze_state_q <= maze_state_d;
            step_count_q <= step_count_d;
            ep_finish_q  <= ep_finish_d;
            timed_out_q  <= timed_out_d;
            state_err_q  <= state_err_d;
            busy_q       <= busy_d;
            trial_done_q <= trial_done_d;
        end
    end

    assign step_req   = step_req_q;
    assign maze_state = maze_state_q;
    assign step_count = step_count_q;
    assign ep_finish  = ep_finish_q;
    assign timed_out  = timed_out_q;
    assign state_err  = state_err_q;
    assign busy       = busy_q;
    assign trial_done = trial_done_q;

endmodule
